vga_timing_gen: RTL

//  Parametrised raster timing generator: next generation of our fixed 640x480 pixel iterator.
//  All porch, sync and active sizes, sync polarities and counter widths are parameters.

---
 rtl/vga_timing_gen.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. Walks a frame of
//   H_TOTAL x V_TOTAL pixel positions (active, front porch, sync, back porch
//   in both directions) on an internal or external pixel enable, and emits
//   registered, mutually aligned sync / display-enable / coordinate outputs
//   plus line/frame/vblank strobes, a wrapping frame counter and run/halt
//   control that only ever stops on a frame boundary.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   pix_ce_in    in   external pixel enable (used only when CE_DIV == 0)
//   run          in   1 = advance raster, 0 = finish current frame then halt
//   h_cnt/v_cnt  out  raw raster position
//   pix_x/pix_y  out  active-area coordinates, 0 outside active video
//   h_sync       out  horizontal sync, active level H_POL
//   v_sync       out  vertical sync, active level V_POL
//   de           out  display enable
//   pix_ce       out  effective pixel enable
//   line_start   out  strobe on the step to h_cnt = 0
//   frame_start  out  strobe on the step to (0,0)
//   vblank_start out  strobe on the step to (0,V_ACTIVE)
//   frame_cnt    out  frames started, wraps
//   halted       out  high while parked at the end of a frame
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned H_W      = 10,
  parameter int unsigned V_W      = 10,
  parameter int unsigned CE_DIV   = 4,
  parameter int unsigned FC_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_ce_in,
  input  logic            run,
  output logic [H_W-1:0]  h_cnt,
  output logic [V_W-1:0]  v_cnt,
  output logic [H_W-1:0]  pix_x,
  output logic [V_W-1:0]  pix_y,
  output logic            h_sync,
  output logic            v_sync,
  output logic            de,
  output logic            pix_ce,
  output logic            line_start,
  output logic            frame_start,
  output logic            vblank_start,
  output logic [FC_W-1:0] frame_cnt,
  output logic            halted
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] H_SS_C   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SE_C   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_SS_C   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SE_C   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((CE_DIV > 0) ? CE_DIV - 1 : 0);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  logic [H_W-1:0]  x_q, x_d;
  logic [V_W-1:0]  y_q, y_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic            ls_q, ls_d;
  logic            fs_q, fs_d;
  logic            vbs_q, vbs_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            halt_q, halt_d;
  logic            ce;
  logic            adv;
  logic            at_end;

  // Pixel enable: external, or a mod-CE_DIV divider (CE_DIV=1 -> always on).
  always_comb begin
    ce    = 1'b0;
    div_d = '0;
    if (CE_DIV == 0) begin
      ce = pix_ce_in;
    end else begin
      ce = (div_q == DIV_LAST);
      if (CE_DIV > 1) begin
        div_d = ce ? '0 : div_q + 1'b1;
      end
    end
  end

  // Run/halt control. HALT parks the counters on the last position of the
  // frame, so resuming is just an ordinary step that wraps to (0,0).
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    at_end  = (h_q == H_LAST) && (v_q == V_LAST);
    unique case (state_q)
      ST_RUN: begin
        if (ce) begin
          if (at_end && !run) state_d = ST_HALT;
          else                adv     = 1'b1;
        end
      end
      ST_HALT: begin
        if (ce && run) begin
          state_d = ST_RUN;
          adv     = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next position and every output decoded from it, so the registered
  // outputs line up with the registered counters in the same cycle.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    de_d   = (h_d < H_ACT_C) && (v_d < V_ACT_C);
    x_d    = de_d ? h_d : '0;
    y_d    = de_d ? v_d : '0;
    hs_d   = ((h_d >= H_SS_C) && (h_d < H_SE_C)) ? H_POL : ~H_POL;
    vs_d   = ((v_d >= V_SS_C) && (v_d < V_SE_C)) ? V_POL : ~V_POL;
    ls_d   = adv && (h_d == '0);
    fs_d   = adv && (h_d == '0) && (v_d == '0);
    vbs_d  = adv && (h_d == '0) && (v_d == V_ACT_C);
    fc_d   = fs_d ? fc_q + 1'b1 : fc_q;
    halt_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      div_q   <= '0;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
      fc_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      vbs_q   <= vbs_d;
      fc_q    <= fc_d;
      halt_q  <= halt_d;
    end
  end

  assign h_cnt        = h_q;
  assign v_cnt        = v_q;
  assign pix_x        = x_q;
  assign pix_y        = y_q;
  assign h_sync       = hs_q;
  assign v_sync       = vs_q;
  assign de           = de_q;
  assign pix_ce       = ce;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;
  assign vblank_start = vbs_q;
  assign frame_cnt    = fc_q;
  assign halted       = halt_q;

endmodule
